// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// 7-segment display sharing one hex-to-segment decoder. Display data is
// double-buffered behind a request/acknowledge handshake and committed only
// when a frame starts at digit 0, so a frame never shows mixed data.
// Optional macro DISP_LEADING_ZERO_BLANK_EN: blank leading zero digits 3..1.
module disp_scan_ctrl #(
    parameter int DIV_BITS  = 16,
    parameter int GUARD_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        upd_req,
    input  logic [15:0] hexs,
    input  logic [3:0]  points,
    input  logic [3:0]  les,
    output logic        upd_ack,
    output logic [3:0]  AN,
    output logic [3:0]  HEX,
    output logic        point,
    output logic        LE,
    output logic        frame_done
);

    // One counter serves both the digit slot and the guard interval, so it
    // must be wide enough for whichever of the two is longer.
    localparam int GB = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam int CW = (DIV_BITS > GB) ? DIV_BITS : GB;
    localparam logic [CW-1:0] SHOW_LAST  = CW'((64'd1 << DIV_BITS) - 64'd1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic [15:0]   stgHex_q, stgHex_d;
    logic [3:0]    stgPoint_q, stgPoint_d;
    logic [3:0]    stgLe_q, stgLe_d;
    logic [15:0]   actHex_q, actHex_d;
    logic [3:0]    actPoint_q, actPoint_d;
    logic [3:0]    actLe_q, actLe_d;
    logic          ack_q, ack_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    hex_q, hex_d;
    logic          point_q, point_d;
    logic          le_q, le_d;
    logic          frameDone_q, frameDone_d;
    logic          commit;
    logic          zeroBlank;

    // Outputs are computed from the next state and registered, so every
    // output lines up exactly with the state the controller is in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            stgHex_q    <= 16'h0000;
            stgPoint_q  <= 4'b0000;
            stgLe_q     <= 4'b1111;
            actHex_q    <= 16'h0000;
            actPoint_q  <= 4'b0000;
            actLe_q     <= 4'b1111;
            ack_q       <= 1'b0;
            an_q        <= 4'b1111;
            hex_q       <= 4'h0;
            point_q     <= 1'b0;
            le_q        <= 1'b1;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            stgHex_q    <= stgHex_d;
            stgPoint_q  <= stgPoint_d;
            stgLe_q     <= stgLe_d;
            actHex_q    <= actHex_d;
            actPoint_q  <= actPoint_d;
            actLe_q     <= actLe_d;
            ack_q       <= ack_d;
            an_q        <= an_d;
            hex_q       <= hex_d;
            point_q     <= point_d;
            le_q        <= le_d;
            frameDone_q <= frameDone_d;
        end
    end

    // Scan sequencing, the staging/commit handshake and the decoder drive.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        stgHex_d    = stgHex_q;
        stgPoint_d  = stgPoint_q;
        stgLe_d     = stgLe_q;
        actHex_d    = actHex_q;
        actPoint_d  = actPoint_q;
        actLe_d     = actLe_q;
        ack_d       = 1'b0;
        an_d        = 4'b1111;
        hex_d       = 4'h0;
        point_d     = 1'b0;
        le_d        = 1'b1;
        frameDone_d = 1'b0;
        commit      = 1'b0;
        zeroBlank   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = SHOW;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d = '0;
                    if (GUARD_CYC == 0) begin
                        idx_d   = idx_q + 2'd1;
                        commit  = (idx_q == 2'd3);
                        state_d = SHOW;
                    end else begin
                        state_d = GUARD;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    commit  = (idx_q == 2'd3);
                    state_d = SHOW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase

        if (!en) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            commit  = 1'b0;
        end

        if (commit) begin
            if (upd_req) begin
                actHex_d   = hexs;
                actPoint_d = points;
                actLe_d    = les;
                ack_d      = 1'b1;
                pending_d  = 1'b0;
            end else if (pending_q) begin
                actHex_d   = stgHex_q;
                actPoint_d = stgPoint_q;
                actLe_d    = stgLe_q;
                ack_d      = 1'b1;
                pending_d  = 1'b0;
            end
        end else if (upd_req) begin
            stgHex_d   = hexs;
            stgPoint_d = points;
            stgLe_d    = les;
            pending_d  = 1'b1;
        end

`ifdef DISP_LEADING_ZERO_BLANK_EN
        case (idx_d)
            2'd3: zeroBlank = (actHex_d[15:12] == 4'h0) && !actPoint_d[3];
            2'd2: zeroBlank = (actHex_d[15:8] == 8'h00) && (actPoint_d[3:2] == 2'b00);
            2'd1: zeroBlank = (actHex_d[15:4] == 12'h000) && (actPoint_d[3:1] == 3'b000);
            default: zeroBlank = 1'b0;
        endcase
`else
        zeroBlank = 1'b0;
`endif

        if (state_d == SHOW) begin
            an_d        = ~(4'b0001 << idx_d);
            hex_d       = actHex_d[{idx_d, 2'b00} +: 4];
            point_d     = actPoint_d[idx_d];
            le_d        = actLe_d[idx_d] | zeroBlank;
            frameDone_d = (idx_d == 2'd3) && (cnt_d == SHOW_LAST);
        end
    end

    assign upd_ack    = ack_q;
    assign AN         = an_q;
    assign HEX        = hex_q;
    assign point      = point_q;
    assign LE         = le_q;
    assign frame_done = frameDone_q;

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. The display shares one hex-to-segment decoder across all four digits.
- Each digit slot drives the decoder inputs (hex code, point, LE blank) together with one active-low anode line. Slots are separated by an all-anodes-off guard interval to suppress ghosting.
- Display data is double-buffered: new data is taken in with a request/acknowledge handshake and committed only at a frame boundary, so a frame is never torn.

Parameters:
- DIV_BITS, 16: each digit is lit for 2^DIV_BITS clock cycles.
- GUARD_CYC, 4: all-off cycles between digit slots. A value of 0 means no guard state.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- en  in  1  scan enable
- upd_req  in  1  single-cycle strobe that captures hexs/points/les
- hexs  in  16  digit codes; digit i = hexs[4i+3:4i]
- points  in  4  decimal point per digit, 1 = lit
- les  in  4  per-digit blank, 1 = digit dark
- upd_ack  out  1  one-cycle pulse when staged data is committed
- AN  out  4  anode selects, active-low, at most one bit low
- HEX  out  4  code to decoder D3..D0
- point  out  1  to decoder point input; the decoder inverts it
- LE  out  1  to decoder LE input; 1 blanks all segments
- frame_done  out  1  one-cycle pulse at the end of the digit-3 slot

Behaviour:
- Reset (asynchronous, active-high):
  - AN=4'b1111, HEX=0, point=0, LE=1, upd_ack=0, frame_done=0.
  - State=IDLE, digit index idx=0, cycle counter cnt=0, pending=0.
  - Staging and active buffers: codes 0, points 0, les 4'b1111.
- All outputs are registered.
- State machine:
  - IDLE
    - AN=1111, LE=1.
    - When en=1, go to SHOW with idx=0 and cnt=0, and perform a commit check.
  - SHOW
    - AN[idx]=0, all other AN bits 1.
    - HEX, point and LE come from active buffer slot idx.
    - cnt increments each cycle. At cnt=2^DIV_BITS-1, clear cnt and go to GUARD, or go directly to the next SHOW if GUARD_CYC=0.
  - GUARD
    - AN=1111, LE=1.
    - After GUARD_CYC cycles: idx=idx+1 mod 4, then SHOW.
  - When idx wraps from 3 to 0, perform a commit check.
- frame_done:
  - Pulses in the cycle the digit-3 SHOW ends.
  - The pulse is emitted regardless of the guard setting.
- Handshake and commit:
  - upd_req=1 captures hexs/points/les into staging and sets pending=1.
  - A later upd_req before the commit overwrites staging. Last request wins.
  - Commit check: if pending, copy staging to active, pulse upd_ack, and clear pending. The new data is visible on the very first cycle of digit-0 SHOW.
  - If upd_req coincides with a commit check, the commit takes the inputs of that same cycle, upd_ack pulses, and pending stays 0.
- en deasserted:
  - In any state, go to IDLE on the next cycle with AN=1111, LE=1, cnt=0, idx=0.
  - Staging and pending are kept. A commit is never partial.
- A digit slot lasts exactly 2^DIV_BITS cycles. The frame period is 4*(2^DIV_BITS+GUARD_CYC) cycles.
- Reset asserted mid-scan returns all outputs to their reset values immediately. Any pending update is discarded.

Optional Feature:
- Macro: DISP_LEADING_ZERO_BLANK_EN.
- When defined:
  - During SHOW, LE is also forced to 1 for digit idx (idx in 3..1) when its code and all higher digit codes are 0 and their points are 0.
  - Digit 0 is never blanked by this rule.
  - The evaluation uses the active buffer.
- When undefined, LE is taken from les only.

Test Plan:
- Reset, then en=1 with DIV_BITS=2, GUARD_CYC=1:
  - AN sequence 1110x4, 1111x1, 1101x4, 1111x1, 1011x4, 1111x1, 0111x4, 1111x1, repeating.
  - frame_done pulses once per 20 cycles.
  - LE=1 throughout, because reset les=1111.
- upd_req with hexs=16'h1234, points=4'b0010, les=0 during digit 2 of a frame:
  - No visible change until the next digit-0 slot.
  - upd_ack pulses on that slot's first cycle.
  - HEX then shows 4,3,2,1 for idx 0..3, and point=1 only on idx 1.
- Two upd_req pulses (16'hAAAA, then 16'h5555) within one frame: a single upd_ack, and 5 is displayed on all digits.
- upd_req with hexs=16'h00F0 in the same cycle as the 3-to-0 wrap: upd_ack in that cycle, HEX=0 on digit 0 immediately, pending=0.
- en dropped mid-SHOW of digit 1: the next cycle shows AN=1111, LE=1. Re-enabling restarts at digit 0 with a full 4-cycle slot.
- With DISP_LEADING_ZERO_BLANK_EN and hexs=16'h0070: LE=1 on digits 3 and 2, LE=0 on digits 1 and 0. With hexs=0, only digit 0 is lit.
